ppe_egress_buffer: RTL and testbench
====================================

PPE_EGRESS_BUFFER -- requirements
Module: ppe_egress_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 Parameter CREDITS, default 4, router input-buffer slots available after reset (1..15).
REQ-003 Parameter PE_ID, default 0, 4-bit node address of the owning PPE.
REQ-004 clk  input  1  sole clock, rising-edge active.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  PPE packetizer offers a packet.
REQ-007 in_ready  output  1  buffer accepts the packet this cycle.
REQ-008 in_packet  input  33  [32:29] dest addr, [28:25] opcode, [24:0] data.
REQ-009 out_valid  output  1  packet launched to router this cycle (credit-based, no ready).
REQ-010 out_packet  output  33  launched packet, same field layout.
REQ-011 credit_return  input  1  single-cycle pulse: router freed one slot.
REQ-012 loop_valid  output  1  self-addressed packet delivered to local depacketizer port.
REQ-013 loop_ready  input  1  local port accepts loop packet.
REQ-014 loop_packet  output  33  self-addressed packet.
REQ-015 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 credit_err  output  1  sticky: credit_return received while counter already at CREDITS.

Function
REQ-017 Input transfer occurs at a rising edge where in_valid and in_ready are both 1; packet written at FIFO tail.
REQ-018 in_ready = (fifo_count < DEPTH), combinational from state only; no push when full even if a pop occurs the same cycle.
REQ-019 FIFO head is examined combinationally (first-word fall-through); pointers wrap modulo DEPTH.
REQ-020 Head with dest addr == PE_ID: loop path; loop_valid = 1, loop_packet = head; popped at edge where loop_ready = 1; consumes no credit.
REQ-021 Head with dest addr != PE_ID: network path; out_valid = 1 and out_packet = head whenever credit_cnt > 0; popped and credit_cnt decremented at that edge.
REQ-022 At most one pop per cycle; loop_valid and out_valid never both 1.
REQ-023 Head blocked (no credit or loop_ready = 0) stalls all later packets; order is strictly preserved.
REQ-024 Earliest latency: packet accepted at edge N is visible on out/loop in cycle following edge N (1 cycle).
REQ-025 Internal credit_cnt, 4 bits: +1 on credit_return, -1 on network launch; both same cycle -> unchanged.
REQ-026 credit_return with credit_cnt == CREDITS and no launch: counter stays at CREDITS, credit_err set to 1 until reset.
REQ-027 Simultaneous push and pop: fifo_count unchanged, both succeed (only if not full before the edge).
REQ-028 out_packet and loop_packet are 0 whenever their valid is 0.

Reset
REQ-029 rst_n = 0 immediately (asynchronously): FIFO empty, pointers 0, fifo_count 0, credit_cnt = CREDITS, credit_err 0, out_valid 0, loop_valid 0, in_ready 0.
REQ-030 in_ready rises at first rising edge after rst_n deasserts; in-flight packets at reset are discarded, not delivered.

Verification
REQ-031 Reset, push 0x1_2_0000ABC (dest 1, PE_ID 0) -> out_valid 1 one cycle later with identical packet; credit_cnt 3.
REQ-032 CREDITS=4, no credit_return, push 6 network packets -> exactly 4 launched, 2 held, fifo_count 2; one credit_return pulse -> 5th launched next cycle.
REQ-033 Push 5 packets with out blocked (0 credits) -> in_ready 0 after 4th, 5th held off; fifo_count 4.
REQ-034 Push dest=PE_ID packet with loop_ready 0 for 3 cycles, then a network packet behind it -> loop_valid held, out_valid 0; on loop_ready 1 loop pops, network packet launches next cycle.
REQ-035 credit_return pulse at reset-level credits -> credit_err 1, credit_cnt stays 4; credit_return and launch same cycle -> count unchanged.
REQ-036 Assert rst_n = 0 mid-stream with 3 packets queued -> all outputs reset without clock edge; no stale packet after release.

Source files
------------

// File: rtl/ppe_egress_buffer.sv
// Egress buffer between a PPE packetizer and its router port: a first-word
// fall-through FIFO that launches network packets against router credits and diverts self-addressed packets to the local port.
module ppe_egress_buffer #(
  parameter int          DEPTH   = 4,
  parameter int          CREDITS = 4,
  parameter logic [3:0]  PE_ID   = 4'd0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [32:0]                in_packet,
  output logic                       out_valid,
  output logic [32:0]                out_packet,
  input  logic                       credit_return,
  output logic                       loop_valid,
  input  logic                       loop_ready,
  output logic [32:0]                loop_packet,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    credit_q, credit_d;
  logic          err_q, err_d;
  logic          ready_en_q;

  logic [32:0]   head;
  logic          nonempty;
  logic          is_local;
  logic          push;
  logic          pop;

  assign head      = mem_q[rd_ptr_q];
  assign nonempty  = (count_q != '0);
  assign is_local  = (head[32:29] == PE_ID);

  assign loop_valid  = nonempty && is_local;
  assign out_valid   = nonempty && !is_local && (credit_q != '0);
  assign loop_packet = loop_valid ? head : '0;
  assign out_packet  = out_valid  ? head : '0;

  // ready_en_q keeps in_ready low until the first edge after reset release
  assign in_ready   = ready_en_q && (count_q < CW'(DEPTH));
  assign fifo_count = count_q;
  assign credit_err = err_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid || (loop_valid && loop_ready);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    credit_d = credit_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // a return coinciding with a launch nets to zero, even at full credit
    case ({credit_return, out_valid})
      2'b10: begin
        if (credit_q == 4'(CREDITS)) err_d = 1'b1;
        else                         credit_d = credit_q + 4'd1;
      end
      2'b01:   credit_d = credit_q - 4'd1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 4'(CREDITS);
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_packet;
  end

endmodule

// File: tb/tb_ppe_egress_buffer.sv
// Directed bench for ppe_egress_buffer (DEPTH 4, CREDITS 4, PE_ID 0).
module tb_ppe_egress_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_packet;
  logic        out_valid;
  logic [32:0] out_packet;
  logic        credit_return;
  logic        loop_valid;
  logic        loop_ready;
  logic [32:0] loop_packet;
  logic [2:0]  fifo_count;
  logic        credit_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned launches;
  logic [32:0] launched [$];

  always #5 clk = ~clk;

  ppe_egress_buffer #(.DEPTH(4), .CREDITS(4), .PE_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .out_valid(out_valid), .out_packet(out_packet),
    .credit_return(credit_return),
    .loop_valid(loop_valid), .loop_ready(loop_ready), .loop_packet(loop_packet),
    .fifo_count(fifo_count), .credit_err(credit_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // sample launches mid-cycle, then advance to 1ns past the next rising edge
  task automatic tick();
    @(negedge clk);
    if (out_valid) begin
      launches++;
      launched.push_back(out_packet);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_packet = '0;
    credit_return = 1'b0; loop_ready = 1'b0;
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    launches = 0;
    launched.delete();
  endtask

  function automatic logic [32:0] pkt(input logic [3:0] d, input logic [3:0] op, input logic [24:0] data);
    return {d, op, data};
  endfunction

  initial begin
    logic [32:0] p [6];
    logic [32:0] lp, np;

    // reset state, observed before any release
    rst_n = 1'b0; in_valid = 1'b0; in_packet = '0;
    credit_return = 1'b0; loop_ready = 1'b0;
    #13;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_loop_valid", loop_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_credit", dut.credit_q, 4);
    check("rst_err", credit_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_edge", in_ready, 1);

    // single network packet, one-cycle latency
    p[0] = pkt(4'h1, 4'h2, 25'h0000ABC);
    in_valid = 1'b1; in_packet = p[0];
    tick();
    in_valid = 1'b0;
    check("lat_out_valid", out_valid, 1);
    check("lat_out_packet", out_packet, p[0]);
    check("lat_loop_valid", loop_valid, 0);
    tick();
    check("lat_credit", dut.credit_q, 3);
    check("lat_count", fifo_count, 0);
    check("idle_out_packet", out_packet, 0);

    // six packets against four credits
    do_reset();
    for (int i = 0; i < 6; i++) begin
      p[i] = pkt(4'(i + 1), 4'h5, 25'(32'h100 + i));
      in_valid = 1'b1; in_packet = p[i];
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("cr_launches", launches, 4);
    check("cr_count", fifo_count, 2);
    check("cr_credit", dut.credit_q, 0);
    check("cr_stalled", out_valid, 0);
    for (int i = 0; i < 4; i++) check($sformatf("cr_order%0d", i), launched[i], p[i]);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("cr_5th_valid", out_valid, 1);
    check("cr_5th_packet", out_packet, p[4]);
    tick();
    check("cr_5th_count", fifo_count, 1);
    check("cr_5th_launches", launches, 5);

    // exhaust credits, then fill the FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_packet = pkt(4'h3, 4'h1, 25'(i));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("full_pre_credit", dut.credit_q, 0);
    check("full_pre_count", fifo_count, 0);
    for (int i = 0; i < 5; i++) begin
      p[i] = pkt(4'h7, 4'h9, 25'(32'h2000 + i));
      in_valid = 1'b1; in_packet = p[i];
      tick();
      if (i == 3) begin
        check("full_ready_after4", in_ready, 0);
        check("full_count_after4", fifo_count, 4);
      end
    end
    in_valid = 1'b0;
    check("full_count_after5", fifo_count, 4);
    check("full_ready_after5", in_ready, 0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("full_head_valid", out_valid, 1);
    check("full_head_packet", out_packet, p[0]);

    // self-addressed head blocks a network packet behind it
    do_reset();
    lp = pkt(4'h0, 4'h3, 25'h155);
    np = pkt(4'h2, 4'h4, 25'h1ABCDEF);
    in_valid = 1'b1; in_packet = lp;
    tick();
    check("loop_valid_early", loop_valid, 1);
    check("loop_packet_early", loop_packet, lp);
    in_packet = np;
    tick();
    in_valid = 1'b0;
    tick();
    check("loop_held_valid", loop_valid, 1);
    check("loop_held_packet", loop_packet, lp);
    check("loop_held_out", out_valid, 0);
    check("loop_held_count", fifo_count, 2);
    check("loop_held_credit", dut.credit_q, 4);
    loop_ready = 1'b1;
    tick();
    loop_ready = 1'b0;
    check("loop_gone_valid", loop_valid, 0);
    check("loop_gone_packet", loop_packet, 0);
    check("net_after_valid", out_valid, 1);
    check("net_after_packet", out_packet, np);
    tick();
    check("net_after_count", fifo_count, 0);
    check("net_after_credit", dut.credit_q, 3);

    // overflow credit return and return coinciding with a launch
    do_reset();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("ovf_err", credit_err, 1);
    check("ovf_credit", dut.credit_q, 4);
    in_valid = 1'b1; in_packet = pkt(4'h5, 4'h0, 25'h42);
    tick();
    in_valid = 1'b0;
    check("both_pre_valid", out_valid, 1);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("both_credit", dut.credit_q, 4);
    check("both_count", fifo_count, 0);
    check("err_sticky", credit_err, 1);

    // asynchronous reset with packets queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_packet = pkt(4'h0, 4'h6, 25'(32'h300 + i));
      tick();
    end
    in_valid = 1'b0;
    check("mid_count", fifo_count, 3);
    check("mid_loop_valid", loop_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_loop_valid", loop_valid, 0);
    check("arst_loop_packet", loop_packet, 0);
    check("arst_count", fifo_count, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    loop_ready = 1'b1;
    launches = 0;
    tick();
    tick();
    check("post_loop_valid", loop_valid, 0);
    check("post_count", fifo_count, 0);
    check("post_in_ready", in_ready, 1);
    check("post_launches", launches, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
